uart_core_param: RTL and testbench

//   Parametrised full-duplex UART core, successor to the fixed 8N1 TX/RX pair.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_core_param_tick.sv | 27 ++
 rtl/uart_core_param.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core: frame state encoding,
// oversampling constants and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int PHASE_W    = $clog2(OVERSAMPLE);

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_core_param_tick.sv
// Oversample tick generator: free-running counter that pulses tick for one
// clk when it reaches baud_div, then restarts from zero.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == baud_div);

  // Count up to baud_div and reload; baud_div = 0 gives a tick every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core with 16x oversampling, valid/ready on
// both sides and RX error reporting.
// Optional feature: define UART_PARITY_EN to add one parity bit per frame
// (PARITY_ODD selects odd parity); without it rx_parity_err is tied low.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
`ifdef UART_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int BIT_W = cnt_w(DATA_BITS);
  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PH_MID   = PHASE_W'(MID_SAMPLE - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

  logic tick;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // ---------------------------------------------------------------- TX ----
  uart_state_e          tx_state, tx_state_n;
  logic [PHASE_W-1:0]   tx_ph, tx_ph_n;
  logic [BIT_W-1:0]     tx_bit, tx_bit_n;
  logic                 tx_stop, tx_stop_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_pend, tx_pend_n;
`ifdef UART_PARITY_EN
  logic                 tx_par, tx_par_n;
`endif
  logic                 tx_end;

  assign tx_end = tick && (tx_ph == PH_LAST);

  // TX state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_ph    <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_pend  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_ph    <= tx_ph_n;
      tx_bit   <= tx_bit_n;
      tx_stop  <= tx_stop_n;
      tx_shift <= tx_shift_n;
      tx_pend  <= tx_pend_n;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next state and line level. A word accepted in IDLE waits (pend) for the
  // next tick so every bit boundary lands on a tick; if the accepting clk is
  // itself a tick the start bit begins immediately.
  always_comb begin
    tx_state_n = tx_state;
    tx_ph_n    = tx_ph;
    tx_bit_n   = tx_bit;
    tx_stop_n  = tx_stop;
    tx_shift_n = tx_shift;
    tx_pend_n  = tx_pend;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    tx_ready   = 1'b0;
    tx         = 1'b1;

    if (tx_state != IDLE && tick) begin
      tx_ph_n = (tx_ph == PH_LAST) ? '0 : tx_ph + PHASE_W'(1);
    end

    unique case (tx_state)
      IDLE: begin
        tx_ready = !tx_pend;
        if (tx_valid && !tx_pend) begin
          tx_shift_n = tx_data;
          tx_pend_n  = 1'b1;
`ifdef UART_PARITY_EN
          tx_par_n   = (^tx_data) ^ PARITY_ODD;
`endif
        end
        if (tick && (tx_pend || tx_valid)) begin
          tx_state_n = START;
          tx_ph_n    = '0;
          tx_pend_n  = 1'b0;
        end
      end
      START: begin
        tx = 1'b0;
        if (tx_end) begin
          tx_state_n = DATA;
          tx_bit_n   = '0;
        end
      end
      DATA: begin
        tx = tx_shift[0];
        if (tx_end) begin
          if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_n = PARITY;
`else
            tx_state_n = STOP;
`endif
            tx_stop_n = 1'b0;
          end else begin
            tx_bit_n   = tx_bit + BIT_W'(1);
            tx_shift_n = tx_shift >> 1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx = tx_par;
        if (tx_end) begin
          tx_state_n = STOP;
          tx_stop_n  = 1'b0;
        end
      end
`endif
      STOP: begin
        tx = 1'b1;
        if (tx_end) begin
          if (tx_stop == STOP_LAST) begin
            tx_state_n = IDLE;
          end else begin
            tx_stop_n = tx_stop + 1'b1;
          end
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX ----
  logic rx_meta, rx_sync, rx_last;
  logic rx_fall;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
    end
  end

  assign rx_fall = rx_last && !rx_sync;

  uart_state_e          rx_state, rx_state_n;
  logic [PHASE_W-1:0]   rx_ph, rx_ph_n;
  logic [BIT_W-1:0]     rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
`ifdef UART_PARITY_EN
  logic                 rx_par, rx_par_n;
`endif
  logic                 rx_mid, rx_end, rx_done;

  assign rx_mid = tick && (rx_ph == PH_MID);
  assign rx_end = tick && (rx_ph == PH_LAST);

  // RX state and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_ph    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_n;
      rx_ph    <= rx_ph_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
`ifdef UART_PARITY_EN
      rx_par   <= rx_par_n;
`endif
    end
  end

  // RX next state: the phase counter restarts on the start edge, each bit is
  // sampled once at its mid tick, and the frame closes at the stop sample so
  // the next start edge can be caught without waiting for the bit end.
  always_comb begin
    rx_state_n = rx_state;
    rx_ph_n    = rx_ph;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
`ifdef UART_PARITY_EN
    rx_par_n   = rx_par;
`endif
    rx_done    = 1'b0;

    if (rx_state != IDLE && tick) begin
      rx_ph_n = (rx_ph == PH_LAST) ? '0 : rx_ph + PHASE_W'(1);
    end

    unique case (rx_state)
      IDLE: begin
        if (rx_fall) begin
          rx_state_n = START;
          rx_ph_n    = '0;
        end
      end
      START: begin
        if (rx_mid && rx_sync) begin
          rx_state_n = IDLE;
        end else if (rx_end) begin
          rx_state_n = DATA;
          rx_bit_n   = '0;
        end
      end
      DATA: begin
        if (rx_mid) begin
          rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
        end
        if (rx_end) begin
          if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_n = PARITY;
`else
            rx_state_n = STOP;
`endif
          end else begin
            rx_bit_n = rx_bit + BIT_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (rx_mid) begin
          rx_par_n = rx_sync;
        end
        if (rx_end) begin
          rx_state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (rx_mid) begin
          rx_done    = 1'b1;
          rx_state_n = IDLE;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // Delivery: a completed word always lands (even with a bad stop bit); if the
  // previous word is still unread and not being taken, flag an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_overrun <= 1'b0;
      if (rx_done) begin
        rx_data       <= rx_shift;
        rx_frame_err  <= !rx_sync;
`ifdef UART_PARITY_EN
        rx_parity_err <= rx_par != ((^rx_shift) ^ PARITY_ODD);
`endif
        rx_valid      <= 1'b1;
        rx_overrun    <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: TX waveform, loopback stream, false
// start, frame error, overrun, optional parity error and reset mid-frame.
module tb_uart_core_param;

  localparam int DW = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   baud_div = 16'd3;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready;
  logic          tx;
  logic          rx;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          rx_overrun;

  logic loop_en = 1'b1;
  logic rx_drv  = 1'b1;
`ifdef UART_PARITY_EN
  logic par_flip = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core_param dut (
    .clk           (clk),
    .rst           (rst),
    .baud_div      (baud_div),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .rx            (rx),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun)
  );

  always @(negedge clk) if (rx_overrun) ovr_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx_drv = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    hold(1'b0, 64);
    for (int i = 0; i < DW; i++) hold(d[i], 64);
`ifdef UART_PARITY_EN
    hold((^d) ^ par_flip, 64);
`endif
    hold(stop, 64);
    hold(1'b1, 64);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  logic          txs [0:999];
  logic [DW-1:0] a_word = 8'hA5;
  logic [DW-1:0] words [3] = '{8'h00, 8'hFF, 8'h3C};

  initial begin
    int k, cnt, ti, ri, cyc, ovr_base;
    logic expb;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_tx_ready", tx_ready, 1);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_rx_data", rx_data, 0);
    check_val("rst_frame_err", rx_frame_err, 0);
    check_val("rst_parity_err", rx_parity_err, 0);
    check_val("rst_overrun", rx_overrun, 0);

    // TX 0xA5, accepted on a tick edge (ticks fall on posedges 4, 8, ...)
    rst = 1'b0;
    repeat (7) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = a_word;
    @(negedge clk);
    tx_valid = 1'b0;
    k = 0;
    while (tx_ready == 1'b0 && k < 1000) begin
      txs[k] = tx;
      k++;
      @(negedge clk);
    end
    check_val("tx_ready_low", k, FRAME_BITS * 64);
    for (int b = 0; b < FRAME_BITS; b++) begin
      if (b == 0) expb = 1'b0;
      else if (b <= DW) expb = a_word[b-1];
`ifdef UART_PARITY_EN
      else if (b == DW + 1) expb = ^a_word;
`endif
      else expb = 1'b1;
      cnt = 0;
      for (int j = 0; j < 64; j++) if (txs[64*b + j] === expb) cnt++;
      check_val($sformatf("tx_bit%0d", b), cnt, 64);
    end
    check_val("loop_a5_valid", rx_valid, 1);
    check_val("loop_a5_data", rx_data, 8'hA5);
    check_val("loop_a5_ferr", rx_frame_err, 0);
    consume();
    check_val("consume_clears", rx_valid, 0);

    // Loopback stream with rx_ready held high
    ti = 0; ri = 0; cyc = 0;
    ovr_base = ovr_cnt;
    rx_ready = 1'b1;
    while (ri < 3 && cyc < 4000) begin
      if (rx_valid) begin
        check_val($sformatf("stream_data%0d", ri), rx_data, words[ri]);
        check_val($sformatf("stream_ferr%0d", ri), rx_frame_err, 0);
        check_val($sformatf("stream_perr%0d", ri), rx_parity_err, 0);
        ri++;
      end
      if (ti < 3) begin
        tx_valid = 1'b1;
        tx_data  = words[ti];
        if (tx_ready) ti++;
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    check_val("stream_count", ri, 3);
    check_val("stream_no_overrun", ovr_cnt - ovr_base, 0);

    // False start, then a good 0x55
    repeat (700) @(negedge clk);
    loop_en = 1'b0;
    hold(1'b1, 64);
    hold(1'b0, 20);
    hold(1'b1, 200);
    check_val("false_start", rx_valid, 0);
    send_frame(8'h55, 1'b1);
    check_val("f55_valid", rx_valid, 1);
    check_val("f55_data", rx_data, 8'h55);
    check_val("f55_ferr", rx_frame_err, 0);
    check_val("f55_perr", rx_parity_err, 0);
    consume();

    // Frame error is reported but the word is still delivered
    send_frame(8'h81, 1'b0);
    check_val("f81_valid", rx_valid, 1);
    check_val("f81_data", rx_data, 8'h81);
    check_val("f81_ferr", rx_frame_err, 1);
    consume();

    // Overrun: two frames with no reader
    ovr_base = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_val("ovr_pulses", ovr_cnt - ovr_base, 1);
    check_val("ovr_valid", rx_valid, 1);
    check_val("ovr_data", rx_data, 8'h22);
    check_val("ovr_ferr", rx_frame_err, 0);
    consume();

`ifdef UART_PARITY_EN
    // Even parity of 0x07 is 1; send 0 instead
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    check_val("par_valid", rx_valid, 1);
    check_val("par_data", rx_data, 8'h07);
    check_val("par_err", rx_parity_err, 1);
    consume();
`endif

    // Reset in the middle of a TX frame (in data bit 0 of 0xF0)
    loop_en  = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    check_val("tx_mid_frame", tx, 0);
    check_val("tx_busy_mid_frame", tx_ready, 0);
    rst = 1'b1;
    #1;
    check_val("rst_async_tx", tx, 1);
    @(negedge clk);
    check_val("rst_mid_tx", tx, 1);
    check_val("rst_mid_tx_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    check_val("rst_partial_discard", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
